montgomery_arbiter: RTL
=======================

Name: montgomery_arbiter

Overview:
- Shares one pipelined 12-bit Montgomery multiplier among NREQ requesters.
- Round-robin arbitration selects at most one operand pair per cycle and issues it to the multiplier's en/a/b inputs.
- The requester ID of each issued operation is recorded in an in-order tag FIFO.
- Each multiplier done pulse is routed back to the requester that issued the operation.
- Sits between the polynomial-arithmetic clients and montgomery_top.

Parameters:
- NREQ, 4, number of requesters (2..8).
- W, 12, operand/result width.
- MAX_OUT, 16, maximum operations in flight; also the tag FIFO depth (power of 2).
- STALL_ON_BUSY, 0, when 1 no issue occurs while mul_busy=1.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NREQ  requester i has an operand pair.
- req_ready  out  NREQ  grant; transfer when req_valid[i]&req_ready[i].
- req_a  in  NREQ*W  operand a, requester i at bits [i*W +: W].
- req_b  in  NREQ*W  operand b, same packing.
- rsp_valid  out  NREQ  one-cycle pulse: result for requester i.
- rsp_r  out  W  result data, shared by all requesters.
- mul_en  out  1  issue strobe to multiplier.
- mul_a  out  W  operand a to multiplier.
- mul_b  out  W  operand b to multiplier.
- mul_busy  in  1  multiplier busy.
- mul_done  in  1  multiplier result valid; results return in issue order.
- mul_r  in  W  multiplier result.
- outstanding  out  $clog2(MAX_OUT)+1  operations in flight.
- err_spurious  out  1  sticky: mul_done seen with no operation outstanding.

Behaviour:
- Reset (rst=1 at a clock edge) forces all of the following to 0:
  - outputs: req_ready, rsp_valid, rsp_r, mul_en, mul_a, mul_b, outstanding, err_spurious;
  - state: RR pointer, tag FIFO pointers.
- Reset mid-operation drops in-flight tags. Any later mul_done for those tags counts as spurious.
- can_issue = (outstanding < MAX_OUT) && !(STALL_ON_BUSY && mul_busy). It uses the registered count; a same-cycle pop does not free a credit.
- req_ready is combinational and one-hot or zero.
  - Grant goes to the first valid requester at or after ptr, scanning ptr, ptr+1, ... NREQ-1, 0.
  - req_ready is 0 for all requesters when !can_issue or no request is valid.
  - req_ready never asserts without req_valid on the same index.
- On a grant to requester g, at the next edge:
  - mul_en<=1, mul_a<=req_a[g], mul_b<=req_b[g];
  - the tag FIFO pushes g;
  - ptr <= (g+1) mod NREQ.
- With no grant, mul_en<=0, mul_a/mul_b hold, and ptr holds. Issue latency from handshake to mul_en is 1 cycle; back-to-back issue is 1 per cycle.
- On mul_done with a non-empty FIFO, at the next edge:
  - pop the tag t;
  - rsp_valid <= onehot(t), rsp_r <= mul_r.
  - Latency from mul_done to rsp_valid is 1 cycle.
  - rsp_valid is otherwise 0; rsp_r holds its last value.
- On mul_done with an empty FIFO and no same-cycle push: no pop, no rsp_valid, err_spurious<=1. err_spurious is sticky until rst.
- outstanding is the FIFO occupancy:
  - +1 on push only, -1 on pop only;
  - unchanged on simultaneous push+pop;
  - it never exceeds MAX_OUT.
- Pointer wrap: FIFO read/write pointers wrap modulo MAX_OUT; full/empty are taken from outstanding.
- Requesters hold req_valid and data stable until accepted. The arbiter does not buffer unaccepted requests.
- Fairness: with all requesters continuously valid, grants rotate 0,1,...,NREQ-1. A requester waits at most NREQ-1 grants.

Test Plan:
- Reset, then idle 5 cycles -> all outputs 0. Then rst=1 for one cycle with 3 ops outstanding -> outstanding=0 and rsp_valid stays 0.
- Requester 2 alone presents a=0x123, b=0x456 -> req_ready[2]=1 that cycle; mul_en=1 with mul_a=0x123, mul_b=0x456 next cycle. A 4-cycle model later pulses mul_done with r=0xABC -> rsp_valid=4'b0100, rsp_r=0xABC one cycle after.
- All 4 requesters valid for 8 cycles -> grant order 0,1,2,3,0,1,2,3. Responses return in the same order with correct one-hot rsp_valid.
- MAX_OUT=16, multiplier withholds done -> exactly 16 issues then req_ready=0 and outstanding=16. A single mul_done re-enables 1 issue on the following cycle.
- Simultaneous push and pop every cycle for 40 cycles (more than 2x FIFO wrap) -> outstanding constant and every tag matches. A scoreboard compares against a golden a*b*R^-1 mod 3329 model.
- mul_done with outstanding=0 -> err_spurious=1 and held; no rsp_valid; the next legal transaction still completes correctly.

Source files
------------

// File: rtl/montgomery_arbiter.sv
// montgomery_arbiter: round-robin sharing of one pipelined Montgomery multiplier
// among NREQ requesters; an in-order tag FIFO routes each result back to its issuer.
module montgomery_arbiter #(
    parameter int NREQ          = 4,
    parameter int W             = 12,
    parameter int MAX_OUT       = 16,
    parameter bit STALL_ON_BUSY = 1'b0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req_valid,
    output logic [NREQ-1:0]          req_ready,
    input  logic [NREQ*W-1:0]        req_a,
    input  logic [NREQ*W-1:0]        req_b,
    output logic [NREQ-1:0]          rsp_valid,
    output logic [W-1:0]             rsp_r,
    output logic                     mul_en,
    output logic [W-1:0]             mul_a,
    output logic [W-1:0]             mul_b,
    input  logic                     mul_busy,
    input  logic                     mul_done,
    input  logic [W-1:0]             mul_r,
    output logic [$clog2(MAX_OUT):0] outstanding,
    output logic                     err_spurious
);
    localparam int IW = $clog2(NREQ);
    localparam int PW = $clog2(MAX_OUT);
    localparam int CW = PW + 1;
    localparam int unsigned NREQ_U = NREQ;

    logic [W-1:0]  a_arr [NREQ];
    logic [W-1:0]  b_arr [NREQ];
    logic [IW-1:0] tag_mem [MAX_OUT];
    logic [IW-1:0] rr_ptr;
    logic [IW-1:0] grant_idx;
    logic          grant_any;
    logic          can_issue;
    logic          push;
    logic          pop;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [IW-1:0] rd_tag;

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
        assign a_arr[gi] = req_a[gi*W +: W];
        assign b_arr[gi] = req_b[gi*W +: W];
    end

    // Credits come from the registered count only; a pop in this cycle frees a slot next cycle.
    assign can_issue = (outstanding < CW'(MAX_OUT)) && !(STALL_ON_BUSY && mul_busy);

    always_comb begin
        int unsigned idx;
        idx       = 0;
        grant_any = 1'b0;
        grant_idx = '0;
        if (can_issue) begin
            for (int unsigned k = 0; k < NREQ_U; k++) begin
                idx = 32'(rr_ptr) + k;
                if (idx >= NREQ_U) idx = idx - NREQ_U;
                if (!grant_any && req_valid[IW'(idx)]) begin
                    grant_any = 1'b1;
                    grant_idx = IW'(idx);
                end
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (grant_any) req_ready[grant_idx] = 1'b1;
    end

    assign push   = grant_any;
    assign pop    = mul_done && (outstanding != '0);
    assign rd_tag = tag_mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) tag_mem[wr_ptr] <= grant_idx;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr       <= '0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            outstanding  <= '0;
            mul_en       <= 1'b0;
            mul_a        <= '0;
            mul_b        <= '0;
            rsp_valid    <= '0;
            rsp_r        <= '0;
            err_spurious <= 1'b0;
        end else begin
            mul_en <= push;
            if (push) begin
                mul_a  <= a_arr[grant_idx];
                mul_b  <= b_arr[grant_idx];
                wr_ptr <= wr_ptr + PW'(1);
                if (grant_idx == IW'(NREQ - 1)) rr_ptr <= '0;
                else                            rr_ptr <= grant_idx + IW'(1);
            end

            if (pop) begin
                rd_ptr    <= rd_ptr + PW'(1);
                rsp_valid <= NREQ'(1) << rd_tag;
                rsp_r     <= mul_r;
            end else begin
                rsp_valid <= '0;
            end

            if (push && !pop)      outstanding <= outstanding + CW'(1);
            else if (pop && !push) outstanding <= outstanding - CW'(1);

            if (mul_done && (outstanding == '0) && !push) err_spurious <= 1'b1;
        end
    end
endmodule
